// File: rtl/lsu_pkg.sv
// Shared load/store codes, FSM encoding and alignment helper for the LSU.
// Used by lsu_align and load_store_unit.
package lsu_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } lsu_state_e;

    function automatic logic misaligned(
        input logic       we,
        input logic [2:0] ld,
        input logic [1:0] st,
        input logic [1:0] a
    );
        logic m;
        m = 1'b0;
        if (we) begin
            case (st)
                ST_SH:   m = a[0];
                ST_SW:   m = (a != 2'b00);
                default: m = 1'b0;
            endcase
        end else begin
            case (ld)
                LD_LB, LD_LBU: m = 1'b0;
                LD_LH, LD_LHU: m = a[0];
                default:       m = (a != 2'b00);
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables and replication for stores,
// lane select and sign/zero extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  load,
    input  logic [1:0]  store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (store)
            ST_SB: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            ST_SH: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            ST_SW: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        byte_lane = 8'h00;
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Codes 101-111 fall through to a full-word load.
    always_comb begin
        rdata_ext = rdata;
        case (load)
            LD_LB:   rdata_ext = {{24{byte_lane[7]}}, byte_lane};
            LD_LH:   rdata_ext = {{16{half_lane[15]}}, half_lane};
            LD_LBU:  rdata_ext = {24'h0, byte_lane};
            LD_LHU:  rdata_ext = {16'h0, half_lane};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store unit: one req/ready bus access per instruction.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  load,
    input  logic [1:0]  store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        valid,
    output logic [31:0] rdata_ext,
    output logic        bus_err,
    output logic        misalign_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  load_q, load_d;
    logic [1:0]  store_q, store_d;
    logic        we_q, we_d;
    logic [7:0]  wait_q, wait_d;
    logic        valid_q, valid_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
`endif

    logic        req;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    assign req = mem_read | mem_write;

    lsu_align u_align (
        .load      (load_q),
        .store     (store_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (bus_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        load_d    = load_q;
        store_d   = store_q;
        we_d      = we_q;
        wait_d    = wait_q;
        rdata_d   = rdata_q;
        valid_d   = 1'b0;
        bus_err_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_d     = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    load_d  = load;
                    store_d = store;
                    we_d    = mem_write;
                    wait_d  = 8'd0;
                    state_d = S_REQ;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned(mem_write, load, store, addr[1:0])) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        mis_d   = 1'b1;
                        rdata_d = 32'h0;
                    end
`endif
                end
            end
            S_REQ: begin
                if (bus_ready) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    if (!we_q) rdata_d = al_rdata;
                end else if (wait_q == 8'(MAX_WAIT - 1)) begin
                    state_d   = S_DONE;
                    valid_d   = 1'b1;
                    bus_err_d = 1'b1;
                    rdata_d   = 32'h0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            load_q    <= 3'b000;
            store_q   <= 2'b00;
            we_q      <= 1'b0;
            wait_q    <= 8'd0;
            valid_q   <= 1'b0;
            bus_err_q <= 1'b0;
            rdata_q   <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            load_q    <= load_d;
            store_q   <= store_d;
            we_q      <= we_d;
            wait_q    <= wait_d;
            valid_q   <= valid_d;
            bus_err_q <= bus_err_d;
            rdata_q   <= rdata_d;
`ifdef MISALIGN_TRAP_EN
            mis_q     <= mis_d;
`endif
        end
    end

    // Stall covers the accepting cycle so the PC holds before REQ is entered.
    assign stall     = ((state_q == S_IDLE) & req) | (state_q == S_REQ);
    assign valid     = valid_q;
    assign bus_err   = bus_err_q;
    assign rdata_ext = rdata_q;
    assign bus_req   = (state_q == S_REQ);
    assign bus_we    = (state_q == S_REQ) & we_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_be    = (state_q != S_REQ) ? 4'b0000 :
                       (we_q ? al_be : 4'b1111);
    assign bus_wdata = al_wdata;
`ifdef MISALIGN_TRAP_EN
    assign misalign_err = mis_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Honours MISALIGN_TRAP_EN when compiled with it.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  load;
    logic [1:0]  store;
    logic [31:0] addr, wdata;
    logic        stall, valid, bus_err, misalign_err;
    logic [31:0] rdata_ext;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ready;

    int pass_cnt = 0;
    int total    = 0;

    load_store_unit #(.MAX_WAIT(16)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .load(load), .store(store), .addr(addr), .wdata(wdata),
        .stall(stall), .valid(valid), .rdata_ext(rdata_ext),
        .bus_err(bus_err), .misalign_err(misalign_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rd, input logic wr, input logic [2:0] ld,
                         input logic [1:0] st, input logic [31:0] a,
                         input logic [31:0] wd);
        mem_read  = rd;
        mem_write = wr;
        load      = ld;
        store     = st;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else pass_cnt++;
        total++; if (valid !== 1'b0) $display("FAIL rst_valid got %b want 0", valid); else pass_cnt++;
        total++; if (bus_req !== 1'b0) $display("FAIL rst_req got %b want 0", bus_req); else pass_cnt++;
        total++; if (bus_we !== 1'b0) $display("FAIL rst_we got %b want 0", bus_we); else pass_cnt++;
        total++; if (bus_err !== 1'b0) $display("FAIL rst_err got %b want 0", bus_err); else pass_cnt++;
        total++; if (misalign_err !== 1'b0) $display("FAIL rst_mis got %b want 0", misalign_err); else pass_cnt++;
        total++; if (bus_be !== 4'b0000) $display("FAIL rst_be got %b want 0000", bus_be); else pass_cnt++;
        total++; if (rdata_ext !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata_ext); else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_store_word;
        @(negedge clk);
        bus_ready = 1'b1;
        drive(1'b0, 1'b1, 3'b000, 2'b10, 32'h100, 32'hDEADBEEF);
        #1;
        total++; if (stall !== 1'b1) $display("FAIL sw_stall0 got %b want 1", stall); else pass_cnt++;
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
        #1;
        total++; if (bus_req !== 1'b1) $display("FAIL sw_req got %b want 1", bus_req); else pass_cnt++;
        total++; if (bus_we !== 1'b1) $display("FAIL sw_we got %b want 1", bus_we); else pass_cnt++;
        total++; if (bus_be !== 4'b1111) $display("FAIL sw_be got %b want 1111", bus_be); else pass_cnt++;
        total++; if (bus_addr !== 32'h100) $display("FAIL sw_addr got %h want 00000100", bus_addr); else pass_cnt++;
        total++; if (bus_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata got %h want deadbeef", bus_wdata); else pass_cnt++;
        total++; if (valid !== 1'b0) $display("FAIL sw_valid1 got %b want 0", valid); else pass_cnt++;
        @(negedge clk);
        #1;
        total++; if (valid !== 1'b1) $display("FAIL sw_valid3 got %b want 1", valid); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL sw_stall_done got %b want 0", stall); else pass_cnt++;
        total++; if (bus_req !== 1'b0) $display("FAIL sw_req_done got %b want 0", bus_req); else pass_cnt++;
        @(negedge clk);
        #1;
        total++; if (valid !== 1'b0) $display("FAIL sw_valid_pulse got %b want 0", valid); else pass_cnt++;
    endtask

    task automatic test_load_byte;
        logic [31:0] exp_tab [2];
        logic [2:0]  code_tab [2];
        exp_tab[0] = 32'hFFFFFF80; code_tab[0] = 3'b000;
        exp_tab[1] = 32'h00000080; code_tab[1] = 3'b011;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus_ready = 1'b1;
            bus_rdata = 32'h80FFFFFF;
            drive(1'b1, 1'b0, code_tab[i], 2'b00, 32'h103, 32'h0);
            @(negedge clk);
            drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
            #1;
            total++; if (bus_we !== 1'b0) $display("FAIL lb_we[%0d] got %b want 0", i, bus_we); else pass_cnt++;
            @(negedge clk);
            #1;
            total++;
            if (valid !== 1'b1 || rdata_ext !== exp_tab[i])
                $display("FAIL lb_data[%0d] got v=%b %h want v=1 %h", i, valid, rdata_ext, exp_tab[i]);
            else pass_cnt++;
        end
        @(negedge clk);
        bus_rdata = 32'h0;
        #1;
        total++; if (rdata_ext !== 32'h00000080) $display("FAIL ld_hold got %h want 00000080", rdata_ext); else pass_cnt++;
    endtask

    task automatic test_half_and_byte_store;
        // sh 0x102
        @(negedge clk);
        bus_ready = 1'b1;
        drive(1'b0, 1'b1, 3'b000, 2'b01, 32'h102, 32'h1234ABCD);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
        #1;
        total++; if (bus_be !== 4'b1100) $display("FAIL sh_be got %b want 1100", bus_be); else pass_cnt++;
        total++; if (bus_wdata !== 32'hABCDABCD) $display("FAIL sh_wdata got %h want abcdabcd", bus_wdata); else pass_cnt++;
        total++; if (bus_addr !== 32'h100) $display("FAIL sh_addr got %h want 00000100", bus_addr); else pass_cnt++;
        repeat (2) @(negedge clk);
        // sb 0x101
        drive(1'b0, 1'b1, 3'b000, 2'b00, 32'h101, 32'hAABBCC55);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
        #1;
        total++; if (bus_be !== 4'b0010) $display("FAIL sb_be got %b want 0010", bus_be); else pass_cnt++;
        total++; if (bus_wdata !== 32'h55555555) $display("FAIL sb_wdata got %h want 55555555", bus_wdata); else pass_cnt++;
        repeat (2) @(negedge clk);
        // lhu 0x102
        bus_rdata = 32'hBEEF0000;
        drive(1'b1, 1'b0, 3'b100, 2'b00, 32'h102, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        total++; if (rdata_ext !== 32'h0000BEEF) $display("FAIL lhu got %h want 0000beef", rdata_ext); else pass_cnt++;
        @(negedge clk);
        // lh 0x100
        bus_rdata = 32'h00008001;
        drive(1'b1, 1'b0, 3'b001, 2'b00, 32'h100, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        total++; if (rdata_ext !== 32'hFFFF8001) $display("FAIL lh got %h want ffff8001", rdata_ext); else pass_cnt++;
        @(negedge clk);
        // store=11: bus cycle with no enables
        drive(1'b0, 1'b1, 3'b000, 2'b11, 32'h108, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
        #1;
        total++;
        if (bus_req !== 1'b1 || bus_be !== 4'b0000)
            $display("FAIL st11 got req=%b be=%b want req=1 be=0000", bus_req, bus_be);
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        int  nreq;
        bit  seen;
        nreq = 0;
        seen = 1'b0;
        @(negedge clk);
        bus_ready = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 2'b00, 32'h200, 32'h0);
        #1;
        total++; if (rdata_ext === 32'h0) $display("FAIL to_pre got %h want nonzero", rdata_ext); else pass_cnt++;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
            #1;
            if (valid === 1'b1) seen = 1'b1;
            else if (bus_req === 1'b1) nreq++;
        end
        total++; if (!seen) $display("FAIL to_valid got none want pulse"); else pass_cnt++;
        total++; if (nreq != 16) $display("FAIL to_cycles got %0d want 16", nreq); else pass_cnt++;
        total++; if (bus_err !== 1'b1) $display("FAIL to_err got %b want 1", bus_err); else pass_cnt++;
        total++; if (rdata_ext !== 32'h0) $display("FAIL to_rdata got %h want 0", rdata_ext); else pass_cnt++;
        total++; if (stall !== 1'b0 || bus_req !== 1'b0)
            $display("FAIL to_release got stall=%b req=%b want 0 0", stall, bus_req);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total++; if (bus_err !== 1'b0) $display("FAIL to_err_pulse got %b want 0", bus_err); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bit vseen;
        vseen = 1'b0;
        @(negedge clk);
        bus_ready = 1'b0;
        drive(1'b0, 1'b1, 3'b000, 2'b10, 32'h300, 32'h1);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
        #1;
        total++; if (bus_req !== 1'b1) $display("FAIL rm_req_pre got %b want 1", bus_req); else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        #1;
        total++; if (bus_req !== 1'b0) $display("FAIL rm_req got %b want 0", bus_req); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL rm_stall got %b want 0", stall); else pass_cnt++;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (valid === 1'b1) vseen = 1'b1;
            @(negedge clk);
            #1;
        end
        total++; if (vseen) $display("FAIL rm_valid got pulse want none"); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus_ready = 1'b1;
        bus_rdata = 32'h11223344;
        drive(1'b1, 1'b0, 3'b010, 2'b00, 32'h104, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (valid !== 1'b1 || stall !== 1'b0 || rdata_ext !== 32'h11223344)
            $display("FAIL b2b_first got v=%b s=%b %h want 1 0 11223344", valid, stall, rdata_ext);
        else pass_cnt++;
        @(negedge clk);
        bus_rdata = 32'h0000AA00;
        drive(1'b1, 1'b0, 3'b011, 2'b00, 32'h105, 32'h0);
        #1;
        total++; if (stall !== 1'b1 || bus_req !== 1'b0)
            $display("FAIL b2b_accept got s=%b r=%b want 1 0", stall, bus_req);
        else pass_cnt++;
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        total++; if (valid !== 1'b1 || rdata_ext !== 32'h000000AA)
            $display("FAIL b2b_second got v=%b %h want 1 000000aa", valid, rdata_ext);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_misalign;
        int  nreq;
        bit  seen;
        nreq = 0;
        seen = 1'b0;
        @(negedge clk);
        bus_ready = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        drive(1'b1, 1'b0, 3'b010, 2'b00, 32'h101, 32'h0);
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
            #1;
            if (bus_req === 1'b1) nreq++;
            if (valid === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) $display("FAIL mis_valid got none want pulse"); else pass_cnt++;
`ifdef MISALIGN_TRAP_EN
        total++; if (nreq != 0) $display("FAIL mis_req got %0d want 0", nreq); else pass_cnt++;
        total++; if (misalign_err !== 1'b1) $display("FAIL mis_err got %b want 1", misalign_err); else pass_cnt++;
        total++; if (rdata_ext !== 32'h0) $display("FAIL mis_rdata got %h want 0", rdata_ext); else pass_cnt++;
`else
        total++; if (nreq != 1) $display("FAIL mis_req got %0d want 1", nreq); else pass_cnt++;
        total++; if (misalign_err !== 1'b0) $display("FAIL mis_err got %b want 0", misalign_err); else pass_cnt++;
        total++; if (rdata_ext !== 32'hCAFEF00D) $display("FAIL mis_rdata got %h want cafef00d", rdata_ext); else pass_cnt++;
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_half_and_byte_store();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_misalign();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
